// File: rtl/collision_scheduler.sv
// collision_scheduler: vblank sprite-overlap engine.
// One shared rectangle comparator walks every object pair.
module collision_scheduler #(
  parameter int N_OBJ  = 4,
  parameter int X_BITS = 8,
  parameter int Y_BITS = 9,
  localparam int P     = N_OBJ * (N_OBJ - 1) / 2,
  localparam int CW    = $clog2(P + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [N_OBJ*(X_BITS+1)-1:0] obj_x,
  input  logic [N_OBJ*(Y_BITS+1)-1:0] obj_y,
  input  logic [N_OBJ*(X_BITS+1)-1:0] obj_w,
  input  logic [N_OBJ*(Y_BITS+1)-1:0] obj_h,
  input  logic [N_OBJ-1:0]            obj_en,
  output logic                        busy,
  output logic                        done,
  output logic [N_OBJ-1:0]            collide,
  output logic [CW-1:0]               hit_count,
  output logic                        overrun
);

  localparam int XW = X_BITS + 1;
  localparam int YW = Y_BITS + 1;
  localparam int IW = $clog2(N_OBJ);
  localparam logic [IW-1:0] LAST_I = IW'(N_OBJ - 2);
  localparam logic [IW-1:0] LAST_J = IW'(N_OBJ - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t state_q, state_d;

  logic [XW-1:0] sx [N_OBJ];
  logic [YW-1:0] sy [N_OBJ];
  logic [XW-1:0] sw [N_OBJ];
  logic [YW-1:0] sh [N_OBJ];
  logic [N_OBJ-1:0] sen;

  logic [IW-1:0]    i_q, j_q;
  logic [N_OBJ-1:0] vec_q, vec_n, pair_bits;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             hit, last;

  // Single comparator on the current pair; sums are one bit wider.
  always_comb begin
    hit = sen[i_q] && sen[j_q]
       && (|sw[i_q]) && (|sh[i_q])
       && (|sw[j_q]) && (|sh[j_q])
       && ({1'b0, sx[i_q]} < {1'b0, sx[j_q]} + {1'b0, sw[j_q]})
       && ({1'b0, sx[j_q]} < {1'b0, sx[i_q]} + {1'b0, sw[i_q]})
       && ({1'b0, sy[i_q]} < {1'b0, sy[j_q]} + {1'b0, sh[j_q]})
       && ({1'b0, sy[j_q]} < {1'b0, sy[i_q]} + {1'b0, sh[i_q]});
    last = (i_q == LAST_I) && (j_q == LAST_J);
    pair_bits = '0;
    for (int k = 0; k < N_OBJ; k++) begin
      pair_bits[k] = hit && ((IW'(k) == i_q) || (IW'(k) == j_q));
    end
    vec_n = vec_q | pair_bits;
    cnt_n = cnt_q + CW'(hit);
  end

  // Next-state: leave IDLE on start, return after the final pair.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Snapshot capture; inputs are ignored until the next accepted start.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      for (int k = 0; k < N_OBJ; k++) begin
        sx[k] <= obj_x[k*XW +: XW];
        sy[k] <= obj_y[k*YW +: YW];
        sw[k] <= obj_w[k*XW +: XW];
        sh[k] <= obj_h[k*YW +: YW];
      end
      sen <= obj_en;
    end
  end

  // Pair walker, work accumulators and published results.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      collide   <= '0;
      hit_count <= '0;
      vec_q     <= '0;
      cnt_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            i_q   <= '0;
            j_q   <= IW'(1);
            vec_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          overrun <= start;
          vec_q   <= vec_n;
          cnt_q   <= cnt_n;
          if (last) begin
            collide   <= vec_n;
            hit_count <= cnt_n;
            done      <= 1'b1;
            busy      <= 1'b0;
          end else if (j_q == LAST_J) begin
            i_q <= i_q + IW'(1);
            j_q <= i_q + IW'(2);
          end else begin
            j_q <= j_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// tb_collision_scheduler: directed checks of the
// pair scan, edge cases, overrun and reset behaviour.
module tb_collision_scheduler;

  localparam int N  = 4;
  localparam int XW = 9;
  localparam int YW = 10;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [N*XW-1:0] obj_x = '0;
  logic [N*YW-1:0] obj_y = '0;
  logic [N*XW-1:0] obj_w = '0;
  logic [N*YW-1:0] obj_h = '0;
  logic [N-1:0]    obj_en = '0;
  logic            busy, done, overrun;
  logic [N-1:0]    collide;
  logic [CW-1:0]   hit_count;

  int vecs = 0;
  int errs = 0;

  collision_scheduler #(.N_OBJ(4), .X_BITS(8), .Y_BITS(9)) dut (
    .clk(clk), .rst(rst), .start(start),
    .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_h(obj_h),
    .obj_en(obj_en), .busy(busy), .done(done),
    .collide(collide), .hit_count(hit_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_obj(input int k, input int x, input int y,
                         input int w, input int h);
    obj_x[k*XW +: XW] = XW'(x);
    obj_y[k*YW +: YW] = YW'(y);
    obj_w[k*XW +: XW] = XW'(w);
    obj_h[k*YW +: YW] = YW'(h);
  endtask

  task automatic basic_cfg();
    set_obj(0, 10, 20, 8, 8);
    set_obj(1, 17, 27, 4, 4);
    set_obj(2, 18, 20, 4, 4);
    set_obj(3, 200, 300, 4, 4);
    obj_en = 4'b1111;
  endtask

  // Pulse start, then count busy cycles until done (bounded).
  task automatic run_scan(output int lat, output int bcnt);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    bcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
      tick();
    end
  endtask

  task automatic chk_res(input string nm, input logic [N-1:0] ec,
                         input logic [CW-1:0] eh);
    vecs++;
    if (collide !== ec) begin
      errs++;
      $display("FAIL %s collide got %b want %b", nm, collide, ec);
    end
    vecs++;
    if (hit_count !== eh) begin
      errs++;
      $display("FAIL %s hit_count got %0d want %0d", nm, hit_count, eh);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vecs++;
    if ({busy, done, overrun} !== 3'b000) begin
      errs++;
      $display("FAIL reset flags got %b want 000", {busy, done, overrun});
    end
    chk_res("reset", 4'b0000, 3'd0);
  endtask

  task automatic test_basic();
    int lat, bcnt;
    basic_cfg();
    run_scan(lat, bcnt);
    vecs++;
    if (lat !== 6) begin
      errs++;
      $display("FAIL basic_latency got %0d want 6", lat);
    end
    vecs++;
    if (bcnt !== 6) begin
      errs++;
      $display("FAIL basic_busy got %0d want 6", bcnt);
    end
    chk_res("basic", 4'b0011, 3'd1);
    tick();
    vecs++;
    if (done !== 1'b0) begin
      errs++;
      $display("FAIL basic_done_width got %b want 0", done);
    end
    chk_res("basic_hold", 4'b0011, 3'd1);
  endtask

  task automatic test_edge_disable();
    int lat, bcnt;
    set_obj(0, 10, 20, 8, 8);
    set_obj(2, 18, 20, 4, 4);
    obj_en = 4'b0101;
    run_scan(lat, bcnt);
    chk_res("edge_touch", 4'b0000, 3'd0);
    set_obj(1, 12, 22, 2, 2);
    obj_en = 4'b0001;
    run_scan(lat, bcnt);
    chk_res("disabled", 4'b0000, 3'd0);
    set_obj(1, 12, 22, 0, 2);
    obj_en = 4'b0011;
    run_scan(lat, bcnt);
    chk_res("zero_w", 4'b0000, 3'd0);
  endtask

  task automatic test_nowrap();
    int lat, bcnt;
    set_obj(0, 508, 0, 8, 10);
    set_obj(1, 2, 0, 4, 10);
    obj_en = 4'b0011;
    run_scan(lat, bcnt);
    chk_res("nowrap", 4'b0000, 3'd0);
    set_obj(1, 510, 0, 4, 10);
    run_scan(lat, bcnt);
    chk_res("high_x", 4'b0011, 3'd1);
  endtask

  task automatic test_overrun();
    int ovr, dn;
    logic [N-1:0] c_at;
    logic [CW-1:0] h_at;
    basic_cfg();
    start = 1'b1;
    tick();
    start = 1'b0;
    ovr = 0;
    dn = 0;
    c_at = '0;
    h_at = '0;
    for (int k = 0; k < 14; k++) begin
      if (overrun) ovr++;
      if (done) begin
        dn++;
        c_at = collide;
        h_at = hit_count;
      end
      if (k == 1) begin
        for (int m = 0; m < N; m++) set_obj(m, 0, 0, 16, 16);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    vecs++;
    if (ovr !== 1) begin
      errs++;
      $display("FAIL overrun_count got %0d want 1", ovr);
    end
    vecs++;
    if (dn !== 1) begin
      errs++;
      $display("FAIL overrun_done_count got %0d want 1", dn);
    end
    vecs++;
    if ({c_at, h_at} !== {4'b0011, 3'd1}) begin
      errs++;
      $display("FAIL snapshot got %b/%0d want 0011/1", c_at, h_at);
    end
  endtask

  task automatic test_reset_mid();
    int dn, lat, bcnt;
    basic_cfg();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++;
    if ({busy, done} !== 2'b00) begin
      errs++;
      $display("FAIL midrst_flags got %b want 00", {busy, done});
    end
    chk_res("midrst", 4'b0000, 3'd0);
    dn = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) dn++;
      tick();
    end
    vecs++;
    if (dn !== 0) begin
      errs++;
      $display("FAIL midrst_no_done got %0d want 0", dn);
    end
    run_scan(lat, bcnt);
    vecs++;
    if (lat !== 6) begin
      errs++;
      $display("FAIL midrst_rescan got %0d want 6", lat);
    end
    chk_res("midrst_rescan", 4'b0011, 3'd1);
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    for (int m = 0; m < N; m++) set_obj(m, 0, 0, 16, 16);
    obj_en = 4'b1111;
    run_scan(lat, bcnt);
    chk_res("all_overlap", 4'b1111, 3'd6);
    run_scan(lat, bcnt);
    vecs++;
    if (lat !== 6 || bcnt !== 6) begin
      errs++;
      $display("FAIL b2b_timing got lat %0d busy %0d want 6 6", lat, bcnt);
    end
    chk_res("b2b", 4'b1111, 3'd6);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edge_disable();
    test_nowrap();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/collision_scheduler.md
# collision_scheduler

Frame-rate collision engine for the arcade video pipeline. It snapshots the N_OBJ sprite rectangles at the start of vertical blank and time-multiplexes a single rectangle-overlap comparator across every unordered object pair, one pair per clock. At the end of the scan it publishes a per-object collision vector and a hit count that game logic reads during the rest of the blanking interval.

## Interface
Parameters:
- N_OBJ, 4, number of object slots; must be ≥ 2.
- X_BITS, 8, x coordinates and widths are X_BITS+1 bits.
- Y_BITS, 9, y coordinates and heights are Y_BITS+1 bits.
- P (localparam), N_OBJ*(N_OBJ-1)/2, number of pairs; CW = $clog2(P+1).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle vblank-start pulse.
- obj_x  in  N_OBJ*(X_BITS+1)  packed left x; slot k occupies bits [k*(X_BITS+1) +: X_BITS+1].
- obj_y  in  N_OBJ*(Y_BITS+1)  packed top y, same packing.
- obj_w  in  N_OBJ*(X_BITS+1)  packed width along x.
- obj_h  in  N_OBJ*(Y_BITS+1)  packed height along y.
- obj_en  in  N_OBJ  slot enable.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when results update.
- collide  out  N_OBJ  bit k = 1 if object k overlaps any other object.
- hit_count  out  CW  number of overlapping pairs.
- overrun  out  1  one-cycle pulse when start arrives while busy.

## Operation
- States: IDLE, SCAN.
- IDLE, start=1: register the snapshot of all obj_* inputs; set i=0, j=1; clear the work vector and work count; busy<=1; go to SCAN. Inputs are never read again until the next start.
- SCAN: each cycle, evaluate pair (i,j) from the snapshot. A pair hits when all of the following hold:
  - en_i and en_j are set.
  - All four sizes (w_i, h_i, w_j, h_j) are nonzero.
  - x_i < x_j+w_j, x_j < x_i+w_i, y_i < y_j+h_j, and y_j < y_i+h_i.
- Sums are computed one bit wider than the operands and never wrap. Edges that only touch (x_i+w_i == x_j) do not hit.
- On a hit, OR bits i and j into the work vector and increment the work count.
- Pair order is lexicographic: (0,1),(0,2)…(0,N-1),(1,2)…(N-2,N-1). After (i,N-1), set i<=i+1, j<=i+2.
- Last pair (N-2,N-1): load collide/hit_count with the final work values including this pair; done<=1; busy<=0; go to IDLE.
- start in SCAN: ignored for the scan (no restart, snapshot unchanged); overrun pulses for one cycle.
- collide and hit_count hold their values between done pulses and change only on the done edge.

## Timing
- Reset values: busy=0, done=0, overrun=0, collide=0, hit_count=0, state=IDLE.
- Reset during SCAN: the scan is abandoned, all outputs return to their reset values, and done does not pulse.
- If start is sampled at edge T, busy is high from T through T+P-1. The pair evaluated on edge T+k is pair number k for k = 1..P. done is high for the cycle following edge T+P, with busy=0 in that same cycle.
- For N_OBJ=4: 6 scan cycles, and done is asserted 6 edges after the start edge.
- start arriving in the same cycle that done is high (state IDLE) is accepted normally, giving back-to-back scans.
- Throughput: one pair per clock, with at most one comparator instance.

## Test plan
- Basic: obj0 (10,20,8,8), obj1 (17,27,4,4), obj2 (18,20,4,4), obj3 (200,300,4,4), all enabled; pulse start. Expect done exactly 6 cycles after start, collide=4'b0011, hit_count=1, and busy high for exactly 6 cycles.
- Edge-touch and disable:
  - obj0 (10,20,8,8) and obj2 (18,20,4,4) only: expect collide=0, hit_count=0.
  - Then obj0 (10,20,8,8) and obj1 (12,22,2,2) with obj1 disabled: expect collide=0.
  - Then obj1 enabled with w=0: expect collide=0.
- No-wrap: obj0 x=508 w=8, obj1 x=2 w=4, identical y=0 h=10. Expect no hit. Then obj1 x=510: expect collide=4'b0011.
- Snapshot/overrun: start, then alter obj_x so that all objects overlap and pulse start again 2 cycles later. Expect overrun pulsed once, results equal to the original snapshot, and a single done.
- Reset mid-scan: assert rst 3 cycles after start. Expect busy=0, collide=0, hit_count=0, and no done. A subsequent start then yields the correct result.
- All-overlap: four identical rectangles (0,0,16,16). Expect collide=4'b1111, hit_count=6. A back-to-back start on the done cycle produces a second done 6 cycles later.
